// File: rtl/idct_precision_scheduler_pkg.sv
// Shared types and default sizes for the IDCT precision scheduler.
// The default state enum and widths are shared by the interface, top and edge counter.
package idct_sched_pkg;

  localparam int CNT_W_DEF         = 32;
  localparam int INFL_W_DEF        = 4;
  localparam int DRAIN_TIMEOUT_DEF = 1024;

  typedef enum logic [1:0] {
    ACC       = 2'd0,
    ACC_DRAIN = 2'd1,
    APX       = 2'd2,
    APX_DRAIN = 2'd3
  } sched_state_e;

endpackage

// File: rtl/idct_precision_scheduler_if.sv
// Control/status bundle between the block-done strobes and the IDCT mode select.
// Duty-cycle controls exist only when IDCT_SCHED_DUTY_EN is defined.
interface idct_sched_if #(
  parameter int CNT_W = idct_sched_pkg::CNT_W_DEF
);
`ifdef IDCT_SCHED_DUTY_EN
  logic [7:0]       duty_apx;
  logic [7:0]       duty_acc;
`endif
  logic             enable;
  logic [CNT_W-1:0] win_start;
  logic [CNT_W-1:0] win_end;
  logic             dct_done;
  logic             idct_done;
  logic             rapx;
  logic             switch_pulse;
  logic             pending;
  logic [CNT_W-1:0] blk_in_cnt;
  logic [CNT_W-1:0] blk_out_cnt;
  logic [CNT_W-1:0] apx_blk_cnt;
  logic             forced_sw;
  logic             infl_err;

  modport master (
`ifdef IDCT_SCHED_DUTY_EN
    output duty_apx, duty_acc,
`endif
    output enable, win_start, win_end, dct_done, idct_done,
    input  rapx, switch_pulse, pending, blk_in_cnt, blk_out_cnt, apx_blk_cnt, forced_sw, infl_err
  );

  modport slave (
`ifdef IDCT_SCHED_DUTY_EN
    input  duty_apx, duty_acc,
`endif
    input  enable, win_start, win_end, dct_done, idct_done,
    output rapx, switch_pulse, pending, blk_in_cnt, blk_out_cnt, apx_blk_cnt, forced_sw, infl_err
  );

endinterface

// File: rtl/idct_precision_scheduler_edge.sv
// Block start/end edge detection and a saturating count of blocks inside the IDCT.
// Any attempt to count past zero or past the maximum sets a sticky error.
module idct_blk_edge_counter
  import idct_sched_pkg::*;
#(
  parameter int INFL_W = INFL_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dct_done_i,
  input  logic              idct_done_i,
  output logic              blk_start_o,
  output logic              blk_end_o,
  output logic [INFL_W-1:0] inflight_o,
  output logic              infl_err_o
);

  localparam logic [INFL_W-1:0] INFL_MAX = '1;

  logic              dct_q;
  logic              idct_q;
  logic [INFL_W-1:0] infl_q;
  logic [INFL_W-1:0] infl_d;
  logic              err_q;
  logic              err_d;

  assign blk_start_o = dct_done_i & ~dct_q;
  assign blk_end_o   = ~idct_done_i & idct_q;
  assign inflight_o  = infl_q;
  assign infl_err_o  = err_q;

  always_comb begin
    infl_d = infl_q;
    err_d  = err_q;
    if (blk_start_o && !blk_end_o) begin
      if (infl_q == INFL_MAX) err_d = 1'b1;
      else                    infl_d = infl_q + INFL_W'(1);
    end else if (blk_end_o && !blk_start_o) begin
      if (infl_q == '0) err_d = 1'b1;
      else              infl_d = infl_q - INFL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dct_q  <= 1'b0;
      idct_q <= 1'b0;
      infl_q <= '0;
      err_q  <= 1'b0;
    end else begin
      dct_q  <= dct_done_i;
      idct_q <= idct_done_i;
      infl_q <= infl_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: rtl/idct_precision_scheduler.sv
// Chooses IDCT accurate/approximate mode per block window; mode changes only commit once the pipe drains.
// Optional feature macro: IDCT_SCHED_DUTY_EN (alternating approximate/accurate runs inside the window).
module idct_precision_scheduler
  import idct_sched_pkg::*;
#(
  parameter int   CNT_W         = CNT_W_DEF,
  parameter int   INFL_W        = INFL_W_DEF,
  parameter int   DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF,
  parameter logic RAPX_RESET    = 1'b0
) (
  input logic         clk,
  input logic         reset,
  idct_sched_if.slave bus
);

  localparam int             TMO_W    = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DRAIN_TIMEOUT - 1);

  logic              blk_start;
  logic              blk_end;
  logic [INFL_W-1:0] inflight;
  logic              infl_err;
  logic              in_win;
  logic              want;
  logic              drained;

  sched_state_e      state_q;
  logic              rapx_q;
  logic              pulse_q;
  logic              forced_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [CNT_W-1:0]  blk_in_q, blk_in_d;
  logic [CNT_W-1:0]  blk_out_q, blk_out_d;
  logic [CNT_W-1:0]  apx_q, apx_d;

  idct_blk_edge_counter #(.INFL_W(INFL_W)) u_edge (
    .clk         (clk),
    .reset       (reset),
    .dct_done_i  (bus.dct_done),
    .idct_done_i (bus.idct_done),
    .blk_start_o (blk_start),
    .blk_end_o   (blk_end),
    .inflight_o  (inflight),
    .infl_err_o  (infl_err)
  );

  // blk_in_q is the index of the next block to enter, so the window decides that block's mode
  assign in_win  = (blk_in_q >= bus.win_start) && (blk_in_q < bus.win_end);
  assign drained = (inflight == '0) && !blk_start;

`ifdef IDCT_SCHED_DUTY_EN
  logic [8:0] pos_q, pos_d;
  logic [8:0] period;
  logic       duty_ok;

  assign period  = {1'b0, bus.duty_apx} + {1'b0, bus.duty_acc};
  assign duty_ok = (bus.duty_acc == 8'd0) || (pos_q < {1'b0, bus.duty_apx});
  assign want    = bus.enable & in_win & duty_ok;

  always_comb begin
    pos_d = pos_q;
    if (!in_win)        pos_d = '0;
    else if (blk_start) pos_d = ((pos_q + 9'd1) >= period) ? 9'd0 : pos_q + 9'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) pos_q <= '0;
    else       pos_q <= pos_d;
  end
`else
  assign want = bus.enable & in_win;
`endif

  always_comb begin
    blk_in_d  = blk_in_q + CNT_W'(blk_start);
    blk_out_d = blk_out_q + CNT_W'(blk_end);
    apx_d     = apx_q + CNT_W'(blk_start & rapx_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blk_in_q  <= '0;
      blk_out_q <= '0;
      apx_q     <= '0;
    end else begin
      blk_in_q  <= blk_in_d;
      blk_out_q <= blk_out_d;
      apx_q     <= apx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RAPX_RESET ? APX : ACC;
      rapx_q   <= RAPX_RESET;
      pulse_q  <= 1'b0;
      forced_q <= 1'b0;
      tmo_q    <= '0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        ACC: if (want) begin
          state_q <= ACC_DRAIN;
          tmo_q   <= '0;
        end
        ACC_DRAIN: begin
          if (!want) state_q <= ACC;
          else if (drained) begin
            state_q <= APX;
            rapx_q  <= 1'b1;
            pulse_q <= 1'b1;
          end else if (tmo_q == TMO_LAST) begin
            state_q  <= APX;
            rapx_q   <= 1'b1;
            pulse_q  <= 1'b1;
            forced_q <= 1'b1;
          end else tmo_q <= tmo_q + TMO_W'(1);
        end
        APX: if (!want) begin
          state_q <= APX_DRAIN;
          tmo_q   <= '0;
        end
        APX_DRAIN: begin
          if (want) state_q <= APX;
          else if (drained) begin
            state_q <= ACC;
            rapx_q  <= 1'b0;
            pulse_q <= 1'b1;
          end else if (tmo_q == TMO_LAST) begin
            state_q  <= ACC;
            rapx_q   <= 1'b0;
            pulse_q  <= 1'b1;
            forced_q <= 1'b1;
          end else tmo_q <= tmo_q + TMO_W'(1);
        end
        default: state_q <= ACC;
      endcase
    end
  end

  assign bus.rapx         = rapx_q;
  assign bus.switch_pulse = pulse_q;
  assign bus.pending      = (state_q == ACC_DRAIN) || (state_q == APX_DRAIN);
  assign bus.blk_in_cnt   = blk_in_q;
  assign bus.blk_out_cnt  = blk_out_q;
  assign bus.apx_blk_cnt  = apx_q;
  assign bus.forced_sw    = forced_q;
  assign bus.infl_err     = infl_err;

endmodule
